// File: rtl/vga_frame_capture.sv
// vga_frame_capture: locks onto TinyVGA syncs, checks line/frame periods and signs each frame's active pixels.
// Define VGA_CAP_CRC_EN for a CRC-16-CCITT signature; otherwise the signature counts non-black pixels.
module vga_frame_capture #(
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int H_START  = 144,
   parameter int V_START  = 35,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [7:0]  vga_in,
   output logic        frame_done,
   output logic [19:0] signature,
   output logic [7:0]  frame_cnt,
   output logic        line_err,
   output logic        frame_err,
   output logic        locked
);
   typedef enum logic {WAIT_VS, FRAME} state_t;
   localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
   localparam logic [9:0]  H_LO    = 10'(H_START);
   localparam logic [9:0]  H_HI    = 10'(H_START + H_ACTIVE);
   localparam logic [9:0]  V_LO    = 10'(V_START);
   localparam logic [9:0]  V_HI    = 10'(V_START + V_ACTIVE);
   localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
   localparam logic [18:0] PIX_TOT = 19'(H_ACTIVE * V_ACTIVE);
`ifdef VGA_CAP_CRC_EN
   localparam logic [19:0] SIG_INIT = 20'h0FFFF;
`else
   localparam logic [19:0] SIG_INIT = 20'h00000;
`endif
   state_t      state, state_nx;
   logic [7:0]  s, s_d, p;
   logic [9:0]  hcnt_q, hcnt, vcnt;
   logic [18:0] pix_acc;
   logic [19:0] sig_acc, sig_nx;
   logic        hs_fall, vs_fall, hs_seen, active, line_bad, line_err_acc, report, clear;
`ifdef VGA_CAP_CRC_EN
   function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction
`endif
   // hcnt is combinational so it already reads 0 in the cycle the hsync fall is seen
   always_comb begin
      hs_fall  = s_d[7] & ~s[7];
      vs_fall  = s_d[3] & ~s[3];
      hcnt     = hs_fall ? 10'd0 : (&hcnt_q ? hcnt_q : hcnt_q + 10'd1);
      line_bad = state == FRAME && hs_fall && hs_seen && ({1'b0, hcnt_q} + 11'd1 != H_TOT);
      active   = state == FRAME && hcnt >= H_LO && hcnt < H_HI && vcnt >= V_LO && vcnt < V_HI;
      p        = {2'b00, s[0], s[4], s[1], s[5], s[2], s[6]};
      report   = ena && vs_fall && state == FRAME;
      clear    = !ena || vs_fall;
      state_nx = !ena ? WAIT_VS : (vs_fall ? FRAME : state);
`ifdef VGA_CAP_CRC_EN
      sig_nx   = {4'h0, crc_byte(sig_acc[15:0], p)};
`else
      sig_nx   = sig_acc + {19'd0, p != 8'd0};
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= WAIT_VS;
      else        state <= state_nx;
   // syncs reset idle-high so the first real low is the first edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s      <= 8'hFF;
         s_d    <= 8'hFF;
         hcnt_q <= 10'h3FF;
         vcnt   <= 10'd0;
         locked <= 1'b0;
      end else begin
         s      <= vga_in;
         s_d    <= s;
         hcnt_q <= hcnt;
         vcnt   <= vs_fall ? 10'd0 : ((hs_fall && !(&vcnt)) ? vcnt + 10'd1 : vcnt);
         locked <= ena && (locked || vs_fall);
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sig_acc      <= SIG_INIT;
         pix_acc      <= 19'd0;
         line_err_acc <= 1'b0;
         hs_seen      <= 1'b0;
      end else if (clear) begin
         sig_acc      <= SIG_INIT;
         pix_acc      <= 19'd0;
         line_err_acc <= 1'b0;
         hs_seen      <= ena && hs_fall;
      end else begin
         hs_seen      <= hs_seen || hs_fall;
         line_err_acc <= line_err_acc || line_bad;
         if (active) begin
            sig_acc <= sig_nx;
            pix_acc <= pix_acc + 19'd1;
         end
      end
   // a hsync coinciding with the vsync still contributes its line check to the report
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         frame_done <= 1'b0;
         signature  <= 20'd0;
         frame_cnt  <= 8'd0;
         line_err   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= report;
         if (report) begin
            signature <= sig_acc;
            frame_cnt <= frame_cnt + 8'd1;
            line_err  <= line_err_acc || line_bad;
            frame_err <= vcnt != V_TOT || pix_acc != PIX_TOT;
         end
      end
endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side checker for the TinyVGA PMOD pin bus that our `tt_um_*` video designs drive on `uo_out`. It samples that bus on the pixel clock, locks onto hsync and vsync edges, measures line and frame periods against 640x480@60 timing, and folds every active pixel into a per-frame signature. It sits next to the design under test, on chip or in a gate-level bench, so frames are checked in hardware rather than by dumping VCDs.

## Interface
- `H_TOTAL`, 800: expected clocks per line (hsync fall to hsync fall).
- `V_TOTAL`, 525: expected lines per frame (vsync fall to vsync fall).
- `H_START`, 144: clocks from detected hsync fall to first active pixel.
- `V_START`, 35: hsync falls after vsync fall up to and including the first active line.
- `H_ACTIVE`, 640 / `V_ACTIVE`, 480: active pixels per line / active lines.
- `clk` input 1: pixel clock, the same clock as the DUT.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: capture enable.
- `vga_in` input 8: TinyVGA bus. [0]=R1, [1]=G1, [2]=B1, [3]=vsync (active low), [4]=R0, [5]=G0, [6]=B0, [7]=hsync (active low).
- `frame_done` output 1: one-cycle pulse when a frame report updates.
- `signature` output 20: signature of the last completed frame.
- `frame_cnt` output 8: number of completed frames, wraps 255 to 0.
- `line_err` output 1: in the last frame, at least one line period was not `H_TOTAL`.
- `frame_err` output 1: in the last frame, the line count was not `V_TOTAL` or the active pixel count was not `H_ACTIVE*V_ACTIVE`.
- `locked` output 1: a vsync fall has been seen since the last reset or `ena` deassertion.

## Operation
- **Input stage:** `vga_in` is registered once into `s`; `s_d` is `s` delayed one more cycle. All logic uses `s` and `s_d`.
- **Edge detection:**
  - hsync fall is `s_d[7]=1` and `s[7]=0`.
  - vsync fall is `s_d[3]=1` and `s[3]=0`.
- **Horizontal counter `hcnt`:** 0 in the hsync-fall cycle, +1 on every other cycle. Saturates at 1023.
- **Line period check:** on every hsync fall in FRAME state, if the previous hsync fall happened in the same frame and `hcnt+1 != H_TOTAL`, set sticky `line_err_acc`.
- **Vertical counter `vcnt`:** counts hsync falls since the last vsync fall. 0 at the vsync fall; saturates at 1023.
- **Active pixel condition:** `H_START <= hcnt < H_START+H_ACTIVE` and `V_START <= vcnt < V_START+V_ACTIVE`, in FRAME state.
- **Per active pixel:**
  - Pixel byte is p = {2'b00, R1, R0, G1, G0, B1, B0}.
  - Signature accumulator is updated with p.
  - `pix_acc` (19-bit) increments.
- **State machine:**
  - WAIT_VS (after reset): on vsync fall go to FRAME; clear accumulators; `locked`=1; no report.
  - FRAME, on vsync fall: latch the report, pulse `frame_done`, clear accumulators, stay in FRAME.
    - `signature` takes the accumulator value.
    - `line_err` takes `line_err_acc`.
    - `frame_err` = (`vcnt != V_TOTAL`) or (`pix_acc != H_ACTIVE*V_ACTIVE`).
    - `frame_cnt` increments.
  - Any state with `ena`=0: go to WAIT_VS, clear `locked` and all accumulators. Report outputs hold their values.
- **Reset values:** every output is 0, state is WAIT_VS, and `s`/`s_d` are 0xFF (syncs idle high, so no false edge comes out of reset).
- **Simultaneous hsync and vsync falls:**
  - The vsync-fall report uses `vcnt` before that cycle's increment.
  - `vcnt` then becomes 0, not 1.
  - The line period check for that hsync fall still applies to `line_err_acc` before it is latched.
- **Saturated `hcnt` (sync lost):** no active pixels are counted and `line_err` is flagged at the next hsync fall.

## Timing
- Pipeline: pin to `s` is 1 cycle; `s` to accumulator update is in the same cycle as the active condition.
- `frame_done` asserts 1 cycle after the vsync-fall cycle. `signature`, `frame_cnt`, `line_err`, `frame_err` change in that same cycle and are stable until the next `frame_done`.
- A pixel driven in the DUT cycle that is `H_START` clocks after its hsync-falling cycle is captured as column 0. The fixed 1-cycle input delay applies equally to syncs and colour.
- The first report comes one full frame after `locked` rises.
- `rst_n` asserted mid-frame forces reset values immediately, asynchronously.

## Configuration
- `VGA_CAP_CRC_EN` defined:
  - Signature = {4'b0, CRC-16-CCITT}.
  - Polynomial 0x1021, init 0xFFFF, MSB first, 8 bits of p per active pixel, no reflection, no final XOR.
- `VGA_CAP_CRC_EN` undefined:
  - Signature = 20-bit count of active pixels with p != 0, starting from 0.
  - No CRC logic is synthesized.

## Test plan
- **Nominal white frames:** ideal 800x525 timing, all pixels 6'h3F, macro undefined, three frames → first `frame_done` is one frame after `locked`; signature=0x4B000; `line_err`=0; `frame_err`=0; `frame_cnt` goes 1, 2.
- **Black frame with CRC:** same timing, all pixels 0, `VGA_CAP_CRC_EN` defined → signature equals the bench CRC-16 model of 307200 zero bytes; two consecutive frames give identical values.
- **Short line:** one line of 799 clocks mid-frame → that frame reports `line_err`=1 with `frame_err` per the model; the next clean frame reports `line_err`=0.
- **Long frame:** frame of 526 lines → `frame_err`=1; signature still covers 480 active lines; the following nominal frame reports `frame_err`=0.
- **`ena` dropped:** `ena` held 0 for 10 cycles mid-frame, then 1 → `locked`=0 immediately; no `frame_done` at the next vsync fall, which re-locks; the report after that is clean; earlier outputs hold throughout.
- **Reset mid-frame:** `rst_n` pulsed low → all outputs 0 asynchronously and state WAIT_VS; sync pins idle-high after reset produce no spurious edge.
